// File: rtl/sobol_pkg.sv
// Shared definitions for the Sobol sequence generator: FSM states, sample
// width and the default (dimension 1) direction vectors. Further dimensions
// can be added here as extra constant arrays.
package sobol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sobol_state_t;

  localparam int SOBOL_W = 32;

  // Entry k-1 holds V[k] = 1 << (32-k), the van der Corput vectors.
  localparam logic [SOBOL_W-1:0] SOBOL_DIR_DIM1 [32] = '{
    32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
    32'h0800_0000, 32'h0400_0000, 32'h0200_0000, 32'h0100_0000,
    32'h0080_0000, 32'h0040_0000, 32'h0020_0000, 32'h0010_0000,
    32'h0008_0000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000,
    32'h0000_8000, 32'h0000_4000, 32'h0000_2000, 32'h0000_1000,
    32'h0000_0800, 32'h0000_0400, 32'h0000_0200, 32'h0000_0100,
    32'h0000_0080, 32'h0000_0040, 32'h0000_0020, 32'h0000_0010,
    32'h0000_0008, 32'h0000_0004, 32'h0000_0002, 32'h0000_0001
  };

endpackage

// File: rtl/sobol_lzb.sv
// Lowest-zero-bit priority encoder: returns the bit position of the lowest
// zero in cnt, which selects the direction vector for the next Gray-code step.
// An all-ones input never occurs in use and maps to 0.
module sobol_lzb #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] cnt,
  output logic [4:0]       idx
);

  // Scan from the top down so the lowest zero bit is the last one to win.
  always_comb begin
    idx = 5'd0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      if (!cnt[i]) begin
        idx = 5'(i);
      end
    end
  end

endmodule

// File: rtl/sobol_seq_gen.sv
// Gray-code Sobol sequence generator: emits len 32-bit samples per start with
// a valid/ready output handshake. Optional macro SOBOL_DIR_LOAD_EN adds the
// dir_* write port and a 32x32 direction register file; without it the
// direction vectors are the package constants and fold away in synthesis.
module sobol_seq_gen
  import sobol_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic [SOBOL_W-1:0] out_x,
  output logic               out_valid,
  input  logic               out_ready
`ifdef SOBOL_DIR_LOAD_EN
  ,
  input  logic               dir_we,
  input  logic [4:0]         dir_addr,
  input  logic [SOBOL_W-1:0] dir_data
`endif
);

  sobol_state_t     state;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] remaining;
  logic [4:0]       lzb_idx;
  logic [SOBOL_W-1:0] dir_vec;
  logic             handshake;

  assign handshake = out_valid & out_ready;

  sobol_lzb #(
    .CNT_W(CNT_W)
  ) u_lzb (
    .cnt(n),
    .idx(lzb_idx)
  );

`ifdef SOBOL_DIR_LOAD_EN
  logic [SOBOL_W-1:0] dir_ram [32];

  // Direction registers: reload defaults on reset, accept writes only in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        dir_ram[k] <= SOBOL_DIR_DIM1[k];
      end
    end else if (state == IDLE && dir_we) begin
      dir_ram[dir_addr] <= dir_data;
    end
  end

  assign dir_vec = dir_ram[lzb_idx];
`else
  assign dir_vec = SOBOL_DIR_DIM1[lzb_idx];
`endif

  // Burst control FSM with registered sample, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      remaining <= '0;
      out_x     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (len != '0) begin
              state     <= RUN;
              n         <= '0;
              out_x     <= '0;
              out_valid <= 1'b1;
              remaining <= len;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (handshake) begin
            out_x <= out_x ^ dir_vec;
            n     <= n + CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              remaining <= '0;
            end else begin
              remaining <= remaining - CNT_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobol_seq_gen.sv
// Self-checking bench for sobol_seq_gen. Expected samples come from a Gray-code
// model (x_i = XOR of V[j+1] over set bits j of i ^ (i >> 1)), are queued when
// a burst is started and popped by a monitor at each observed handshake.
module tb_sobol_seq_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [31:0] out_x;
  logic        out_valid;
  logic        out_ready;
`ifdef SOBOL_DIR_LOAD_EN
  logic        dir_we;
  logic [4:0]  dir_addr;
  logic [31:0] dir_data;
`endif

  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dir_model [32];
  logic        stall_pending = 1'b0;
  logic [31:0] stall_x = '0;

  always #5 clk = ~clk;

  sobol_seq_gen #(
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .len(len),
    .busy(busy),
    .done(done),
    .out_x(out_x),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SOBOL_DIR_LOAD_EN
    ,
    .dir_we(dir_we),
    .dir_addr(dir_addr),
    .dir_data(dir_data)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic void resetModel();
    for (int j = 0; j < 32; j++) dir_model[j] = 32'h8000_0000 >> j;
  endfunction

  function automatic logic [31:0] modelSample(input int idx);
    logic [31:0] g;
    logic [31:0] x;
    g = 32'(idx) ^ (32'(idx) >> 1);
    x = '0;
    for (int j = 0; j < 32; j++) if (g[j]) x = x ^ dir_model[j];
    return x;
  endfunction

  // Monitor: score each handshake, check stall stability and count done pulses.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (stall_pending) checkOutput("stall_hold", out_x, stall_x);
      if (out_ready) begin
        if (exp_q.size() == 0) checkOutput("extra_sample", 32'(exp_q.size()), 32'd1);
        else checkOutput("sample", out_x, exp_q.pop_front());
        stall_pending = 1'b0;
      end else begin
        stall_pending = 1'b1;
        stall_x = out_x;
      end
    end else begin
      stall_pending = 1'b0;
    end
    if (done === 1'b1) done_count++;
  end

  task automatic applyStimulus(input int n_len);
    for (int i = 0; i < n_len; i++) exp_q.push_back(modelSample(i));
    start = 1'b1;
    len = 16'(n_len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: start pulses in RUN/DONE,
  // 3: direction write attempted during RUN.
  task automatic runBurst(input int n_len, input int mode, input int exp_cycles);
    int cyc;
    int done_before;
    applyStimulus(n_len);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("valid_after_start", 32'(out_valid), 32'd1);
    done_before = done_count;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      out_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mode == 2 && cyc == 2) begin
        start = 1'b1;
        len = 16'd2;
      end
`ifdef SOBOL_DIR_LOAD_EN
      if (mode == 3 && cyc == 1) begin
        dir_we = 1'b1;
        dir_addr = 5'd1;
        dir_data = 32'hDEAD_BEEF;
      end
`endif
      @(posedge clk); #1;
      start = 1'b0;
`ifdef SOBOL_DIR_LOAD_EN
      dir_we = 1'b0;
`endif
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("burst_cycles", 32'(cyc), 32'(exp_cycles));
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("valid_at_done", 32'(out_valid), 32'd0);
    if (mode == 2) begin
      start = 1'b1;
      len = 16'd3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("valid_idle", 32'(out_valid), 32'd0);
    checkOutput("done_count", 32'(done_count - done_before), 32'd1);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    out_ready = 1'b0;
`ifdef SOBOL_DIR_LOAD_EN
    dir_we = 1'b0;
    dir_addr = '0;
    dir_data = '0;
`endif
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_x", out_x, 32'd0);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] burst len=5, ready held high");
    runBurst(5, 0, 5);

    $display("[TB] burst len=5, ready toggling");
    runBurst(5, 1, 13);

    $display("[TB] burst len=0");
    applyStimulus(0);
    checkOutput("len0_done", 32'(done), 32'd1);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    checkOutput("len0_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("len0_done_clear", 32'(done), 32'd0);
    checkOutput("len0_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

`ifdef SOBOL_DIR_LOAD_EN
    $display("[TB] direction load V[1]=0x12345678");
    dir_we = 1'b1;
    dir_addr = 5'd0;
    dir_data = 32'h1234_5678;
    dir_model[0] = 32'h1234_5678;
    @(posedge clk); #1;
    dir_we = 1'b0;
    runBurst(3, 3, 3);
    @(posedge clk); #1;
`endif

    $display("[TB] reset during len=8 burst");
    applyStimulus(8);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_out_x", out_x, 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    exp_q.delete();
    resetModel();
    rst = 1'b0;
    @(posedge clk); #1;
    runBurst(4, 0, 4);

    $display("[TB] start pulses during RUN and DONE");
    runBurst(6, 2, 6);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_idle_busy", 32'(busy), 32'd0);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
